// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto a single SRAM-style bus.
// Only one transaction can be outstanding; request fields are registered on the grant edge.
module mem_bus_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // owner / last_grant: 1 = data port, 0 = instruction port
  logic owner;
  logic last_grant;
  logic grant_en;
  logic grant_data;

  // Data wins when alone, always in fixed mode, or when inst had the previous grant.
  always_comb begin
    grant_en   = (state == IDLE) && (inst_req || data_req);
    grant_data = data_req && (!inst_req || !FAIR || !last_grant);
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inst_req || data_req) state_nxt = ADDR;
      ADDR:    if (bus_addr_ok)          state_nxt = RESP;
      RESP:    if (bus_data_ok)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are combinational from the bus acks, qualified by state and owner.
  always_comb begin
    bus_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    data_rdata   = 32'h0;
    case (state)
      ADDR: begin
        bus_req      = 1'b1;
        inst_addr_ok = bus_addr_ok && !owner;
        data_addr_ok = bus_addr_ok && owner;
      end
      RESP: begin
        inst_data_ok = bus_data_ok && !owner;
        data_data_ok = bus_data_ok && owner;
        if (inst_data_ok) inst_rdata = bus_rdata;
        if (data_data_ok) data_rdata = bus_rdata;
      end
      default: ;
    endcase
  end

  // Granted request fields, held stable through ADDR and RESP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner      <= 1'b0;
      last_grant <= 1'b0;
      bus_wr     <= 1'b0;
      bus_wstrb  <= 4'h0;
      bus_addr   <= 32'h0;
      bus_wdata  <= 32'h0;
    end else if (grant_en) begin
      owner      <= grant_data;
      last_grant <= grant_data;
      if (grant_data) begin
        bus_wr    <= data_wr;
        bus_wstrb <= data_wstrb;
        bus_addr  <= data_addr;
        bus_wdata <= data_wdata;
      end else begin
        bus_wr    <= 1'b0;
        bus_wstrb <= 4'h0;
        bus_addr  <= inst_addr;
        bus_wdata <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Checks a round-robin and a fixed-priority arbiter, driven by shared stimulus,
// against a transaction-level reference model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, data_wr, bus_addr_ok, bus_data_ok;
  logic [31:0] inst_addr, data_addr, data_wdata, bus_rdata;
  logic [3:0]  data_wstrb;

  logic        f_iaok, f_idok, f_daok, f_ddok, f_breq, f_bwr;
  logic [31:0] f_irdata, f_drdata, f_baddr, f_bwdata;
  logic [3:0]  f_bwstrb;
  logic        x_iaok, x_idok, x_daok, x_ddok, x_breq, x_bwr;
  logic [31:0] x_irdata, x_drdata, x_baddr, x_bwdata;
  logic [3:0]  x_bwstrb;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.FAIR(1'b1)) u_fair (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(f_iaok), .inst_data_ok(f_idok), .inst_rdata(f_irdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(f_daok), .data_data_ok(f_ddok), .data_rdata(f_drdata),
    .bus_req(f_breq), .bus_wr(f_bwr), .bus_wstrb(f_bwstrb),
    .bus_addr(f_baddr), .bus_wdata(f_bwdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  mem_bus_arbiter #(.FAIR(1'b0)) u_fixed (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(x_iaok), .inst_data_ok(x_idok), .inst_rdata(x_irdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(x_daok), .data_data_ok(x_ddok), .data_rdata(x_drdata),
    .bus_req(x_breq), .bus_wr(x_bwr), .bus_wstrb(x_bwstrb),
    .bus_addr(x_baddr), .bus_wdata(x_bwdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  logic [69:0] f_resp, f_bus, x_resp, x_bus;
  assign f_resp = {2'b00, f_iaok, f_idok, f_irdata, f_daok, f_ddok, f_drdata};
  assign f_bus  = {f_breq, f_bwr, f_bwstrb, f_baddr, f_bwdata};
  assign x_resp = {2'b00, x_iaok, x_idok, x_irdata, x_daok, x_ddok, x_drdata};
  assign x_bus  = {x_breq, x_bwr, x_bwstrb, x_baddr, x_bwdata};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model, index 0 = round-robin DUT, 1 = fixed-priority DUT.
  // busy: 0 nothing outstanding, 1 waiting for address ack, 2 waiting for response.
  int       busy [2];
  bit       who_data [2];
  bit       prev_data [2];
  bit       m_wr [2];
  bit [3:0]  m_strb [2];
  bit [31:0] m_addr [2];
  bit [31:0] m_wdata [2];

  function automatic void model_reset(input int i);
    busy[i] = 0; who_data[i] = 1'b0; prev_data[i] = 1'b0;
    m_wr[i] = 1'b0; m_strb[i] = 4'h0; m_addr[i] = 32'h0; m_wdata[i] = 32'h0;
  endfunction

  function automatic void model_advance(input int i);
    bit pick;
    case (busy[i])
      0: if (inst_req || data_req) begin
        if (inst_req && data_req) pick = (i == 1) ? 1'b1 : !prev_data[i];
        else                      pick = data_req;
        who_data[i] = pick; prev_data[i] = pick; busy[i] = 1;
        m_wr[i]    = pick ? data_wr    : 1'b0;
        m_strb[i]  = pick ? data_wstrb : 4'h0;
        m_addr[i]  = pick ? data_addr  : inst_addr;
        m_wdata[i] = pick ? data_wdata : 32'h0;
      end
      1: if (bus_addr_ok) busy[i] = 2;
      default: if (bus_data_ok) busy[i] = 0;
    endcase
  endfunction

  function automatic logic [69:0] exp_bus(input int i);
    return {busy[i] == 1, m_wr[i], m_strb[i], m_addr[i], m_wdata[i]};
  endfunction

  function automatic logic [69:0] exp_resp(input int i);
    bit iao, dao, ido, ddo;
    iao = (busy[i] == 1) && bus_addr_ok && !who_data[i];
    dao = (busy[i] == 1) && bus_addr_ok &&  who_data[i];
    ido = (busy[i] == 2) && bus_data_ok && !who_data[i];
    ddo = (busy[i] == 2) && bus_data_ok &&  who_data[i];
    return {2'b00, iao, ido, ido ? bus_rdata : 32'h0, dao, ddo, ddo ? bus_rdata : 32'h0};
  endfunction

  bit inst_acc, data_acc;
  bit gq_f [$];
  bit gq_x [$];

  // One clock: compare both DUTs with the model, then advance the model across the edge.
  task automatic step();
    #1;
    if (!resetn) begin
      model_reset(0); model_reset(1);
      check("rst_zero_f", f_resp | f_bus, 70'h0);
      check("rst_zero_x", x_resp | x_bus, 70'h0);
    end
    check("fair_resp", f_resp, exp_resp(0));
    check("fair_bus", f_bus, exp_bus(0));
    check("fixed_resp", x_resp, exp_resp(1));
    check("fixed_bus", x_bus, exp_bus(1));
    inst_acc = f_iaok;
    data_acc = f_daok;
    if (f_breq && bus_addr_ok) gq_f.push_back(f_daok);
    if (x_breq && bus_addr_ok) gq_x.push_back(x_daok);
    @(posedge clk);
    if (resetn) begin model_advance(0); model_advance(1); end
    @(negedge clk);
  endtask

  task automatic set_bus(input logic ao, input logic dok, input logic [31:0] rd);
    bus_addr_ok = ao; bus_data_ok = dok; bus_rdata = rd;
  endtask

  task automatic do_reset();
    resetn = 1'b0; step(); resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
    data_addr = 0; data_wdata = 0;
    set_bus(0, 0, 0);
    model_reset(0); model_reset(1);
    @(negedge clk);
    step(); step();
    resetn = 1'b1;
    step();

    // Single load: request cycle 0, address ack cycle 2, response cycle 4.
    data_req = 1; data_wr = 0; data_addr = 32'h1C00_0010;
    step();
    #1 check("load_req_c1", f_breq, 1); step();
    set_bus(1, 0, 0);
    #1 check("load_aok_c2", f_daok, 1); step();
    data_req = 0; set_bus(0, 0, 0);
    #1 check("load_req_c3", f_breq, 0); step();
    set_bus(0, 1, 32'hDEAD_BEEF);
    #1 check("load_dok_c4", {f_ddok, f_drdata}, {1'b1, 32'hDEAD_BEEF});
    check("load_inst_zero", {f_iaok, f_idok, f_irdata}, 0);
    step();
    set_bus(0, 0, 0); step();

    // Store with a delayed address ack; fields must not follow the changing inputs.
    data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_addr = 32'h0000_0040;
    data_wdata = 32'h1234_5678;
    step();
    for (int k = 0; k < 3; k++) begin
      #1 check("store_hold", {f_breq, f_bwr, f_bwstrb, f_bwdata}, {1'b1, 1'b1, 4'b0011, 32'h1234_5678});
      data_wdata = 32'hFFFF_0000 + 32'(k);
      step();
    end
    set_bus(1, 0, 0);
    step();
    data_req = 0; data_wr = 0; set_bus(0, 1, 32'h5555_AAAA);
    #1 check("store_dok", f_ddok, 1); step();
    set_bus(0, 0, 0); step();

    // Continuous tie with immediate acks.
    do_reset();
    gq_f.delete(); gq_x.delete();
    inst_req = 1; inst_addr = 32'h0000_1000; data_req = 1; data_addr = 32'h0000_2000;
    set_bus(1, 1, 32'hCAFE_0001);
    for (int k = 0; k < 12; k++) step();
    check("tie_fair_count", 70'(gq_f.size()), 4);
    check("tie_fixed_count", 70'(gq_x.size()), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < gq_f.size()) check($sformatf("tie_fair_g%0d", k), gq_f[k], (k % 2 == 0) ? 1 : 0);
      if (k < gq_x.size()) check($sformatf("tie_fixed_g%0d", k), gq_x[k], 1);
    end
    data_req = 0;
    for (int k = 0; k < 6; k++) step();
    check("fixed_inst_after", gq_x.size() > 4 ? 70'(gq_x[4]) : 70'h2, 0);
    inst_req = 0; set_bus(0, 0, 0);
    for (int k = 0; k < 3; k++) step();

    // Reset while waiting for the response, then a late bus_data_ok.
    data_req = 1; data_addr = 32'h0000_3000; step();
    set_bus(1, 0, 0); step();
    data_req = 0; set_bus(0, 1, 32'h0BAD_0BAD);
    resetn = 0; step();
    resetn = 1;
    #1 check("rst_resp_dok", {f_ddok, x_ddok, f_breq}, 0); step();
    step();
    set_bus(0, 0, 0);

    // Stray acks while idle.
    set_bus(1, 1, 32'h7777_7777);
    for (int k = 0; k < 3; k++) begin
      #1 check("stray_idle", {f_breq, f_idok, f_ddok, f_iaok, f_daok}, 0);
      step();
    end
    set_bus(0, 0, 0); step();

    // Random traffic with held requests and occasional resets.
    inst_acc = 0; data_acc = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!resetn) resetn = 1;
      else if ($urandom_range(0, 79) == 0) resetn = 0;
      if (inst_acc || !inst_req) begin
        inst_req = ($urandom_range(0, 2) == 0);
        inst_addr = $urandom;
      end
      if (data_acc || !data_req) begin
        data_req = ($urandom_range(0, 2) == 0);
        data_wr = 1'($urandom);
        data_wstrb = 4'($urandom);
        data_addr = $urandom;
        data_wdata = $urandom;
      end
      set_bus(1'($urandom), 1'($urandom), $urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter FAIR, default 1, selects round-robin (1) or fixed data-first (0) arbitration on simultaneous requests.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 inst_req  input  1  fetch request, held high until inst_addr_ok.
REQ-005 inst_addr  input  32  fetch address.
REQ-006 inst_addr_ok  output  1  fetch request accepted by the bus.
REQ-007 inst_data_ok  output  1  fetch data returned; inst_rdata is valid this cycle.
REQ-008 inst_rdata  output  32  fetch read data.
REQ-009 data_req  input  1  load/store request, held high until data_addr_ok.
REQ-010 data_wr  input  1  1 = store, 0 = load.
REQ-011 data_wstrb  input  4  store byte enables.
REQ-012 data_addr  input  32  load/store address.
REQ-013 data_wdata  input  32  store data.
REQ-014 data_addr_ok  output  1  load/store request accepted by the bus.
REQ-015 data_data_ok  output  1  load data returned or store completed.
REQ-016 data_rdata  output  32  load read data.
REQ-017 bus_req  output  1  shared SRAM-bus request.
REQ-018 bus_wr, bus_wstrb, bus_addr, bus_wdata  output  1/4/32/32  registered request fields.
REQ-019 bus_addr_ok  input  1  bus accepted the request.
REQ-020 bus_data_ok  input  1  bus response valid.
REQ-021 bus_rdata  input  32  bus read data.

Function
REQ-022 The FSM SHALL have three states: IDLE, ADDR and RESP. At most one transaction SHALL be outstanding.
REQ-023 In IDLE, if either request is high, the block SHALL grant one requester. On that edge it SHALL register the granted fields into the bus_* registers and the owner flag, then move to ADDR.
REQ-024 For a granted fetch, the block SHALL drive bus_wr=0, bus_wstrb=4'h0 and bus_wdata=0.
REQ-025 Arbitration when only one request is high: grant that requester.
REQ-026 Arbitration when both requests are high and FAIR=1: grant the requester that did not receive the previous grant; last_grant resets to inst, so data wins the first tie.
REQ-027 Arbitration when both requests are high and FAIR=0: always grant data.
REQ-028 bus_req SHALL be 1 exactly while in ADDR. The bus_* fields SHALL stay stable until bus_addr_ok.
REQ-029 In ADDR with bus_addr_ok=1, the owner's *_addr_ok SHALL be 1 in that same cycle (combinational from bus_addr_ok and owner), and the FSM SHALL move to RESP. The non-owner's addr_ok SHALL stay 0.
REQ-030 In RESP with bus_data_ok=1, the owner's *_data_ok SHALL be 1 in that cycle, with *_rdata equal to bus_rdata (combinational), and the FSM SHALL return to IDLE.
REQ-031 Grant latency SHALL be one cycle: a request in IDLE produces bus_req on the next cycle. A back-to-back transaction SHALL therefore have exactly one IDLE cycle between bus_data_ok and the next bus_req.
REQ-032 The block SHALL ignore bus_data_ok in IDLE and ADDR, and bus_addr_ok in IDLE and RESP, without changing state.
REQ-033 *_rdata SHALL be 0 whenever the corresponding *_data_ok is 0.
REQ-034 Requests that arrive in ADDR or RESP SHALL NOT be granted until the FSM returns to IDLE. Their addr_ok SHALL stay 0 until then.
REQ-035 last_grant SHALL update only on a grant edge.

Reset
REQ-036 When resetn is asserted, in any state including mid-transaction, the block SHALL immediately force the FSM to IDLE, last_grant to inst, owner to inst, and all bus_* registers to 0.
REQ-037 During reset, every output SHALL be 0.
REQ-038 A transaction in flight at reset SHALL be dropped. No addr_ok or data_ok SHALL be issued for it after reset release.

Verification
REQ-039 Single load: data_req=1, data_addr=0x1C000010, bus_addr_ok on cycle 2, bus_data_ok with bus_rdata=0xDEADBEEF on cycle 4. Required response: bus_req cycles 1-2, data_addr_ok on cycle 2, data_data_ok with data_rdata=0xDEADBEEF on cycle 4, inst_* outputs all 0.
REQ-040 Tie with FAIR=1: inst_req and data_req held high continuously, bus acks immediately. Required response: grants alternate data, inst, data, inst, with one IDLE cycle between transactions.
REQ-041 Tie with FAIR=0, same stimulus as REQ-040: every grant goes to data while data_req stays high, and inst is granted only after data_req drops.
REQ-042 Store: data_wr=1, data_wstrb=4'b0011, data_wdata=0x12345678. Required response: bus_wr=1, bus_wstrb=4'b0011, bus_wdata=0x12345678, all stable until bus_addr_ok, then data_data_ok on bus_data_ok.
REQ-043 Reset in RESP: pulse resetn low, then drive bus_data_ok=1. Required response: FSM in IDLE, no data_ok asserted, all outputs 0 during reset.
REQ-044 Stray ack: bus_data_ok=1 while IDLE. Required response: no state change and no *_data_ok asserted.
